// File: rtl/ias_pkg.sv
// Shared opcode and FSM state definitions for the parametrised IAS accumulator core.
package ias_pkg;

    localparam logic [7:0] OP_NOP      = 8'd0;
    localparam logic [7:0] OP_LOAD     = 8'd1;
    localparam logic [7:0] OP_STORE    = 8'd2;
    localparam logic [7:0] OP_ADD      = 8'd3;
    localparam logic [7:0] OP_SUB      = 8'd4;
    localparam logic [7:0] OP_JUMP     = 8'd5;
    localparam logic [7:0] OP_STORE_AC = 8'd6;
    localparam logic [7:0] OP_JUMP_POS = 8'd7;
    localparam logic [7:0] OP_LOAD_MQ  = 8'd8;
    localparam logic [7:0] OP_MUL      = 8'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITE_BACK
    } state_t;

    // Opcodes that never touch memory skip the address range check.
    function automatic logic is_mem_op(input logic [7:0] opc);
        return !(opc == OP_NOP || opc == OP_JUMP || opc == OP_JUMP_POS);
    endfunction

endpackage

// File: rtl/ias_ram_p.sv
// Single-port-write / single-port-read synchronous RAM backing the IAS core.
module ias_ram_p #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/ias_core_p.sv
// Parametrised IAS accumulator core: one handshaked instruction per 5-state FSM pass.
// Define IAS_MUL_EN to enable opcode 9 (MUL); otherwise opcode 9 retires with err.
module ias_core_p
    import ias_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int OPC_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] mq_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              done,
    output logic              carry,
    output logic              err
);

`ifdef IAS_MUL_EN
    localparam logic [7:0] OP_MAX = OP_MUL;
`else
    localparam logic [7:0] OP_MAX = OP_LOAD_MQ;
`endif
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    state_t            state_q;
    logic [OPC_W-1:0]  ir_opc_q;
    logic [ADDR_W-1:0] ir_addr_q;
    logic [DATA_W-1:0] ir_data_q;
    logic [DATA_W-1:0] ac_q, mq_q;
    logic [ADDR_W-1:0] pc_q;
    logic              carry_q, done_q, err_q, ready_q, illegal_q;

    logic [DATA_W-1:0] ac_d, mq_d, ram_wdata, ram_rdata;
    logic [ADDR_W-1:0] pc_d;
    logic              carry_d, exec_we, ram_we, addr_oob;
    logic [DATA_W:0]   sum, diff;
`ifdef IAS_MUL_EN
    logic [2*DATA_W-1:0] prod;
`endif

    // RAM is read from the latched IR address; data is stable from DECODE onward.
    ias_ram_p #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ir_addr_q),
        .wdata_i(ram_wdata),
        .raddr_i(ir_addr_q),
        .rdata_o(ram_rdata)
    );

    assign addr_oob = ({1'b0, ir_addr_q} >= DEPTH_L);
    assign ram_we   = exec_we && (state_q == S_EXECUTE) && !reset;

    always_comb begin
        ac_d      = ac_q;
        mq_d      = mq_q;
        carry_d   = carry_q;
        pc_d      = pc_q + ADDR_W'(1);
        exec_we   = 1'b0;
        ram_wdata = ir_data_q;
        sum       = {1'b0, ac_q} + {1'b0, ram_rdata};
        diff      = {1'b0, ac_q} - {1'b0, ram_rdata};
`ifdef IAS_MUL_EN
        prod      = {{DATA_W{1'b0}}, mq_q} * {{DATA_W{1'b0}}, ram_rdata};
`endif
        if (!illegal_q) begin
            case (ir_opc_q)
                OP_LOAD:     ac_d = ram_rdata;
                OP_STORE:    exec_we = 1'b1;
                OP_ADD:      {carry_d, ac_d} = sum;
                OP_SUB:      {carry_d, ac_d} = diff;
                OP_JUMP:     pc_d = ir_addr_q;
                OP_STORE_AC: begin
                    exec_we   = 1'b1;
                    ram_wdata = ac_q;
                end
                OP_JUMP_POS: if (!ac_q[DATA_W-1]) pc_d = ir_addr_q;
                OP_LOAD_MQ:  mq_d = ram_rdata;
`ifdef IAS_MUL_EN
                OP_MUL:      {ac_d, mq_d} = prod;
`endif
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_opc_q  <= '0;
            ir_addr_q <= '0;
            ir_data_q <= '0;
            ac_q      <= '0;
            mq_q      <= '0;
            pc_q      <= '0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (instr_valid && ready_q) begin
                        ir_opc_q  <= opcode;
                        ir_addr_q <= address;
                        ir_data_q <= data_in;
                        ready_q   <= 1'b0;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    illegal_q <= (ir_opc_q > OP_MAX) || (is_mem_op(ir_opc_q) && addr_oob);
                    state_q   <= S_EXECUTE;
                end
                // Results land at the end of EXECUTE so they are visible while done is high.
                S_EXECUTE: begin
                    ac_q    <= ac_d;
                    mq_q    <= mq_d;
                    carry_q <= carry_d;
                    pc_q    <= pc_d;
                    done_q  <= 1'b1;
                    err_q   <= illegal_q;
                    state_q <= S_WRITE_BACK;
                end
                S_WRITE_BACK: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign data_out    = ac_q;
    assign mq_out      = mq_q;
    assign pc_out      = pc_q;
    assign done        = done_q;
    assign carry       = carry_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ias_core_p.sv
// Directed testbench for ias_core_p (memory depth reduced to 200 to exercise range errors).
module tb_ias_core_p;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready, done, carry, err;
    logic [7:0] opcode = '0, address = '0, data_in = '0;
    logic [7:0] data_out, mq_out, pc_out;
    int         checks = 0;
    int         errors = 0;
    int         lat;

    always #5 clk = ~clk;

    ias_core_p #(
        .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .OPC_W(8)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .address(address), .data_in(data_in), .data_out(data_out),
        .mq_out(mq_out), .pc_out(pc_out), .done(done), .carry(carry), .err(err)
    );

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Issues one instruction and returns at the falling edge where done is seen.
    task automatic issue(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] d,
                         output int l);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        opcode = opc; address = a; data_in = d; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0; opcode = 8'hFF; address = 8'hEE; data_in = 8'hDD;
        l = 1;
        while (!done && l < 20) begin
            @(negedge clk);
            l++;
        end
        if (l >= 20) begin
            errors++; checks++;
            $display("FAIL done_timeout: opcode %0d got no done within %0d cycles", opc, l);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (data_out !== 8'd0) begin errors++; $display("FAIL rst_ac: got %0d want 0", data_out); end
        checks++; if (mq_out !== 8'd0) begin errors++; $display("FAIL rst_mq: got %0d want 0", mq_out); end
        checks++; if (pc_out !== 8'd0) begin errors++; $display("FAIL rst_pc: got %0d want 0", pc_out); end
        checks++; if ({done, err, carry} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {done, err, carry}); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", instr_ready); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        issue(8'd2, 8'd1, 8'd150, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL store_latency: got %0d want 4", lat); end
        issue(8'd1, 8'd1, 8'd0, lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL load_latency: got %0d want 4", lat); end
        checks++; if (data_out !== 8'd150) begin errors++; $display("FAIL load_ac: got %0d want 150", data_out); end
        checks++; if (pc_out !== 8'd2) begin errors++; $display("FAIL load_pc: got %0d want 2", pc_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", err); end
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL ready_busy: got %b want 0", instr_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL ready_after: got %b want 1", instr_ready); end
    endtask

    task automatic test_store();
        issue(8'd2, 8'd1, 8'd123, lat);
        issue(8'd1, 8'd1, 8'd0, lat);
        checks++; if (data_out !== 8'd123) begin errors++; $display("FAIL store_load_ac: got %0d want 123", data_out); end
        issue(8'd6, 8'd2, 8'd0, lat);
        issue(8'd8, 8'd2, 8'd0, lat);
        checks++; if (mq_out !== 8'd123) begin errors++; $display("FAIL store_ac_mq: got %0d want 123", mq_out); end
        checks++; if (pc_out !== 8'd6) begin errors++; $display("FAIL store_pc: got %0d want 6", pc_out); end
    endtask

    task automatic test_addsub();
        issue(8'd2, 8'd11, 8'd25, lat);
        issue(8'd2, 8'd12, 8'd50, lat);
        issue(8'd1, 8'd11, 8'd0, lat);
        issue(8'd3, 8'd12, 8'd0, lat);
        checks++; if (data_out !== 8'd75) begin errors++; $display("FAIL add_ac: got %0d want 75", data_out); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL add_carry: got %b want 0", carry); end
        issue(8'd4, 8'd12, 8'd0, lat);
        checks++; if (data_out !== 8'd25) begin errors++; $display("FAIL sub_ac: got %0d want 25", data_out); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sub_carry: got %b want 0", carry); end
        issue(8'd4, 8'd12, 8'd0, lat);
        checks++; if (data_out !== 8'd231) begin errors++; $display("FAIL sub_wrap_ac: got %0d want 231", data_out); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL sub_borrow: got %b want 1", carry); end
        issue(8'd2, 8'd13, 8'd200, lat);
        issue(8'd2, 8'd14, 8'd100, lat);
        issue(8'd1, 8'd13, 8'd0, lat);
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL carry_hold: got %b want 1", carry); end
        issue(8'd3, 8'd14, 8'd0, lat);
        checks++; if (data_out !== 8'd44) begin errors++; $display("FAIL add_wrap_ac: got %0d want 44", data_out); end
        checks++; if (carry !== 1'b1) begin errors++; $display("FAIL add_carry_out: got %b want 1", carry); end
    endtask

    task automatic test_jump();
        issue(8'd5, 8'd20, 8'd0, lat);
        checks++; if (pc_out !== 8'd20) begin errors++; $display("FAIL jump_pc: got %0d want 20", pc_out); end
        issue(8'd2, 8'd15, 8'd128, lat);
        issue(8'd1, 8'd15, 8'd0, lat);
        issue(8'd7, 8'd40, 8'd0, lat);
        checks++; if (pc_out !== 8'd23) begin errors++; $display("FAIL jpos_not_taken: got %0d want 23", pc_out); end
        issue(8'd2, 8'd16, 8'd5, lat);
        issue(8'd1, 8'd16, 8'd0, lat);
        issue(8'd7, 8'd40, 8'd0, lat);
        checks++; if (pc_out !== 8'd40) begin errors++; $display("FAIL jpos_taken: got %0d want 40", pc_out); end
        issue(8'd5, 8'd255, 8'd0, lat);
        issue(8'd0, 8'd0, 8'd0, lat);
        checks++; if (pc_out !== 8'd0) begin errors++; $display("FAIL pc_wrap: got %0d want 0", pc_out); end
    endtask

    task automatic test_errors();
        issue(8'd15, 8'd3, 8'd0, lat);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_opc_err: got %b want 1", err); end
        checks++; if (data_out !== 8'd5) begin errors++; $display("FAIL bad_opc_ac: got %0d want 5", data_out); end
        checks++; if (pc_out !== 8'd1) begin errors++; $display("FAIL bad_opc_pc: got %0d want 1", pc_out); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", err); end
        issue(8'd1, 8'd210, 8'd0, lat);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oob_err: got %b want 1", err); end
        checks++; if (data_out !== 8'd5) begin errors++; $display("FAIL oob_ac: got %0d want 5", data_out); end
        issue(8'd2, 8'd199, 8'd77, lat);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL last_addr_err: got %b want 0", err); end
        issue(8'd1, 8'd199, 8'd0, lat);
        checks++; if (data_out !== 8'd77) begin errors++; $display("FAIL last_addr_ac: got %0d want 77", data_out); end
        checks++; if (pc_out !== 8'd4) begin errors++; $display("FAIL err_pc: got %0d want 4", pc_out); end
    endtask

    task automatic test_mul();
        issue(8'd2, 8'd4, 8'd20, lat);
        issue(8'd8, 8'd4, 8'd0, lat);
        issue(8'd2, 8'd3, 8'd30, lat);
        issue(8'd9, 8'd3, 8'd0, lat);
`ifdef IAS_MUL_EN
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mul_err: got %b want 0", err); end
        checks++; if (data_out !== 8'd2) begin errors++; $display("FAIL mul_hi: got %0d want 2", data_out); end
        checks++; if (mq_out !== 8'd88) begin errors++; $display("FAIL mul_lo: got %0d want 88", mq_out); end
`else
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mul_illegal_err: got %b want 1", err); end
        checks++; if (data_out !== 8'd77) begin errors++; $display("FAIL mul_illegal_ac: got %0d want 77", data_out); end
        checks++; if (mq_out !== 8'd20) begin errors++; $display("FAIL mul_illegal_mq: got %0d want 20", mq_out); end
`endif
    endtask

    task automatic test_reset_abort();
        issue(8'd2, 8'd30, 8'd5, lat);
        @(negedge clk);
        opcode = 8'd2; address = 8'd30; data_in = 8'd99; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", instr_ready); end
        checks++; if ({data_out, mq_out, pc_out} !== 24'd0) begin errors++; $display("FAIL abort_regs: got %h want 0", {data_out, mq_out, pc_out}); end
        checks++; if ({done, err, carry} !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b want 000", {done, err, carry}); end
        issue(8'd1, 8'd30, 8'd0, lat);
        checks++; if (data_out !== 8'd5) begin errors++; $display("FAIL abort_mem: got %0d want 5", data_out); end
        checks++; if (pc_out !== 8'd1) begin errors++; $display("FAIL abort_pc: got %0d want 1", pc_out); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_addsub();
        test_jump();
        test_errors();
        test_mul();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
